// File: rtl/stp_pkg.sv
// Shared constants and helpers for the framed serial-to-parallel shifter.
package stp_pkg;

  localparam logic [31:0] RESET_ONES = '1;

  // Bit-counter width: ceil(log2(n)), never less than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stp_bit_counter.sv
// Per-word bit counter; rollover flags the shift that completes a word.
module stp_bit_counter
  import stp_pkg::*;
#(
  parameter int NUM_BITS = 4,
  parameter int CNT_W    = cnt_w(NUM_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [CNT_W-1:0] count,
  output logic             rollover
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BITS - 1);

  assign rollover = count_enable && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (rollover) count <= '0;
      else          count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/flex_stp_sr_framed.sv
// Serial-to-parallel shift register that captures each completed word into
// a holding register with a one-cycle word_valid strobe.
module flex_stp_sr_framed
  import stp_pkg::*;
#(
  parameter int                    NUM_BITS  = 4,
  parameter bit                    SHIFT_MSB = 1'b1,
  parameter logic [NUM_BITS-1:0]   RESET_VAL = RESET_ONES[NUM_BITS-1:0],
  parameter int                    CNT_W     = cnt_w(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  output logic [CNT_W-1:0]    bit_count
);

  logic [NUM_BITS-1:0] shifted;
  logic                do_shift;
  logic                rollover;

  assign do_shift = shift_enable && !clear;

  generate
    if (SHIFT_MSB) begin : g_msb_first
      assign shifted = {parallel_out[NUM_BITS-2:0], serial_in};
    end else begin : g_lsb_first
      assign shifted = {serial_in, parallel_out[NUM_BITS-1:1]};
    end
  endgenerate

  stp_bit_counter #(
    .NUM_BITS (NUM_BITS),
    .CNT_W    (CNT_W)
  ) u_bit_counter (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (do_shift),
    .count        (bit_count),
    .rollover     (rollover)
  );

  // word_out captures the same value parallel_out takes on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parallel_out <= RESET_VAL;
      word_out     <= RESET_VAL;
      word_valid   <= 1'b0;
    end else if (clear) begin
      parallel_out <= RESET_VAL;
      word_valid   <= 1'b0;
    end else if (shift_enable) begin
      parallel_out <= shifted;
      word_valid   <= rollover;
      if (rollover) word_out <= shifted;
    end else begin
      word_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flex_stp_sr_framed.sv
// Directed bench for flex_stp_sr_framed in 4-bit MSB, 4-bit LSB and 8-bit MSB builds.
module tb_flex_stp_sr_framed;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic shift_enable = 1'b0;
  logic serial_in = 1'b0;

  logic [3:0] m4_par, m4_word, l4_par, l4_word;
  logic [7:0] m8_par, m8_word;
  logic       m4_valid, l4_valid, m8_valid;
  logic [1:0] m4_cnt, l4_cnt;
  logic [2:0] m8_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flex_stp_sr_framed #(.NUM_BITS(4), .SHIFT_MSB(1'b1)) dut_m4 (
    .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .serial_in(serial_in), .parallel_out(m4_par), .word_out(m4_word),
    .word_valid(m4_valid), .bit_count(m4_cnt));

  flex_stp_sr_framed #(.NUM_BITS(4), .SHIFT_MSB(1'b0)) dut_l4 (
    .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .serial_in(serial_in), .parallel_out(l4_par), .word_out(l4_word),
    .word_valid(l4_valid), .bit_count(l4_cnt));

  flex_stp_sr_framed #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_m8 (
    .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .serial_in(serial_in), .parallel_out(m8_par), .word_out(m8_word),
    .word_valid(m8_valid), .bit_count(m8_cnt));

  // Drive inputs, wait for the rising edge, then settle 1 time unit past it.
  task automatic step(input logic en, input logic sb, input logic clr);
    shift_enable = en;
    serial_in    = sb;
    clear        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    shift_enable = 1'b0;
    clear        = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    shift_enable = 1'b0;
    clear = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m4_par !== 4'hF || m4_word !== 4'hF || m4_cnt !== 2'd0 || m4_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_m4: par=%b word=%b cnt=%0d valid=%b, need 1111 1111 0 0",
               m4_par, m4_word, m4_cnt, m4_valid);
    end
    checks++;
    if (m8_par !== 8'hFF || m8_word !== 8'hFF || m8_cnt !== 3'd0 || m8_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_m8: par=%h word=%h cnt=%0d valid=%b, need ff ff 0 0",
               m8_par, m8_word, m8_cnt, m8_valid);
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Stream 1,0,1,1 into both 4-bit builds.
  task automatic test_msb_lsb_word();
    logic [3:0] bits;
    logic [3:0] exp_valid;
    logic [1:0] exp_cnt [4];
    bits      = 4'b1011;
    exp_valid = 4'b0001;
    exp_cnt   = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[3-i], 1'b0);
      checks++;
      if (m4_valid !== exp_valid[3-i] || m4_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL msb_step%0d: valid=%b cnt=%0d, need %b %0d",
                 i, m4_valid, m4_cnt, exp_valid[3-i], exp_cnt[i]);
      end
      checks++;
      if (l4_valid !== exp_valid[3-i]) begin
        errors++;
        $display("FAIL lsb_step%0d: valid=%b, need %b", i, l4_valid, exp_valid[3-i]);
      end
    end
    checks++;
    if (m4_par !== 4'b1011 || m4_word !== 4'b1011) begin
      errors++;
      $display("FAIL msb_word: par=%b word=%b, need 1011 1011", m4_par, m4_word);
    end
    checks++;
    if (l4_par !== 4'b1101 || l4_word !== 4'b1101) begin
      errors++;
      $display("FAIL lsb_word: par=%b word=%b, need 1101 1101", l4_par, l4_word);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (m4_valid !== 1'b0 || l4_valid !== 1'b0 || m4_word !== 4'b1011) begin
      errors++;
      $display("FAIL pulse_width: m4_valid=%b l4_valid=%b word=%b, need 0 0 1011",
               m4_valid, l4_valid, m4_word);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] byte_in;
    int pulses;
    byte_in = 8'hA5;
    pulses  = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, byte_in[7-i], 1'b0);
      if (m8_valid) pulses++;
      checks++;
      if (m8_valid !== (i == 7)) begin
        errors++;
        $display("FAIL gap_valid%0d: valid=%b, need %b", i, m8_valid, (i == 7));
      end
      if (i % 2 == 1 && i != 7) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, ~byte_in[7-i], 1'b0);
          if (m8_valid) pulses++;
          checks++;
          if (m8_cnt !== 3'(i + 1) || m8_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_hold%0d_%0d: cnt=%0d valid=%b, need %0d 0",
                     i, g, m8_cnt, m8_valid, i + 1);
          end
        end
      end
    end
    step(1'b0, 1'b0, 1'b0);
    if (m8_valid) pulses++;
    checks++;
    if (m8_word !== 8'hA5 || m8_par !== 8'hA5 || m8_cnt !== 3'd0 || pulses != 1) begin
      errors++;
      $display("FAIL gap_word: word=%h par=%h cnt=%0d pulses=%0d, need a5 a5 0 1",
               m8_word, m8_par, m8_cnt, pulses);
    end
  endtask

  task automatic test_clear();
    logic [3:0] w1, w2;
    w1 = 4'b0110;
    w2 = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, w1[3-i], 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m4_cnt !== 2'd2 || m4_par !== 4'b1011) begin
      errors++;
      $display("FAIL clear_pre: cnt=%0d par=%b, need 2 1011", m4_cnt, m4_par);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (m4_par !== 4'hF || m4_cnt !== 2'd0 || m4_word !== 4'b0110 || m4_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_apply: par=%b cnt=%0d word=%b valid=%b, need 1111 0 0110 0",
               m4_par, m4_cnt, m4_word, m4_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w2[3-i], 1'b0);
      checks++;
      if (m4_valid !== (i == 3)) begin
        errors++;
        $display("FAIL clear_next%0d: valid=%b, need %b", i, m4_valid, (i == 3));
      end
    end
    checks++;
    if (m4_word !== 4'b0001 || m4_par !== 4'b0001) begin
      errors++;
      $display("FAIL clear_word: word=%b par=%b, need 0001 0001", m4_word, m4_par);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] w1, w2;
    w1 = 4'b0010;
    w2 = 4'b1110;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, w1[3-i], 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    shift_enable = 1'b0;
    checks++;
    if (m4_word !== 4'b0010 || m4_cnt !== 2'd3 || m4_par !== 4'b0101) begin
      errors++;
      $display("FAIL areset_pre: word=%b cnt=%0d par=%b, need 0010 3 0101",
               m4_word, m4_cnt, m4_par);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m4_par !== 4'hF || m4_word !== 4'hF || m4_cnt !== 2'd0 || m4_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: par=%b word=%b cnt=%0d valid=%b, need 1111 1111 0 0",
               m4_par, m4_word, m4_cnt, m4_valid);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w2[3-i], 1'b0);
      checks++;
      if (m4_valid !== (i == 3)) begin
        errors++;
        $display("FAIL areset_next%0d: valid=%b, need %b", i, m4_valid, (i == 3));
      end
    end
    checks++;
    if (m4_word !== 4'b1110) begin
      errors++;
      $display("FAIL areset_word: word=%b, need 1110", m4_word);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    logic [3:0] exp_word [8];
    bits     = 8'b1100_0101;
    exp_word = '{4'hF, 4'hF, 4'hF, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0101};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[7-i], 1'b0);
      checks++;
      if (m4_valid !== (i == 3 || i == 7) || m4_word !== exp_word[i]) begin
        errors++;
        $display("FAIL b2b_edge%0d: valid=%b word=%b, need %b %b",
                 i, m4_valid, m4_word, (i == 3 || i == 7), exp_word[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (m4_valid !== 1'b0 || m4_word !== 4'b0101) begin
      errors++;
      $display("FAIL b2b_after: valid=%b word=%b, need 0 0101", m4_valid, m4_word);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_msb_lsb_word();
    test_gapped();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
